transmitter_queue: RTL and testbench

- Transmit-side counterpart of the node's receive queue.
- Accepts one word per cycle from the node controller, tagged with a 2-bit destination select, and buffers it in one of three per-direction FIFOs: left, self, right.
- Each FIFO drains independently onto its own outgoing link with a valid/ready handshake.
- Destination codes match the receive-side cycler codes: 00 = left, 01 = self, 10 = right.

---
 rtl/txq_pkg.sv | 24 ++
 rtl/txq_fifo.sv | 62 ++++++
 rtl/transmitter_queue.sv | 126 ++++++++++++
 tb/tb_transmitter_queue.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/txq_pkg.sv
// Shared definitions for the transmit queue: destination codes and full-flag bit positions.
// Latency: none (constants and a pure helper function only).
// Backpressure: n/a; direction codes match the receive-side cycler so both halves agree.
package txq_pkg;

  // Destination select codes carried on s; 11 names no direction and is always discarded.
  typedef enum logic [1:0] {
    DIR_LEFT  = 2'b00,
    DIR_SELF  = 2'b01,
    DIR_RIGHT = 2'b10,
    DIR_NONE  = 2'b11
  } dir_e;

  // Bit positions inside the 3-bit full vector {right, self, left}.
  localparam int FULL_IDX_LEFT  = 0;
  localparam int FULL_IDX_SELF  = 1;
  localparam int FULL_IDX_RIGHT = 2;

  // True when the select names a real outgoing direction.
  function automatic logic dir_is_valid(input logic [1:0] d);
    return d != DIR_NONE;
  endfunction

endpackage

// File: rtl/txq_fifo.sv
// Single-direction word FIFO with a combinational head and valid/ready pop.
// Latency: a push at edge N is visible on head/valid right after edge N when the FIFO was empty.
// Backpressure: full is a start-of-cycle flag; pushes while full are ignored, pops need valid.
module txq_fifo #(
  parameter int width = 32,
  parameter int depth = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [width-1:0] push_data,
  input  logic             pop,
  output logic [width-1:0] head,
  output logic             valid,
  output logic             full
);

  // Pointer width follows depth; depth is a power of two so pointers wrap naturally.
  localparam int ptr_w = $clog2(depth);
  localparam logic [ptr_w:0] depth_cnt = (ptr_w + 1)'(depth);

  logic [width-1:0] mem [depth];
  logic [ptr_w-1:0] wr_ptr;
  logic [ptr_w-1:0] rd_ptr;
  logic [ptr_w:0]   count;
  logic             push_ok;
  logic             pop_ok;

  // Status is derived from the registered count, so it reflects the start of the cycle.
  assign valid   = (count != '0);
  assign full    = (count == depth_cnt);
  assign push_ok = push && !full;
  assign pop_ok  = pop && valid;

  // Head is read straight from storage and forced to zero when nothing is buffered.
  assign head = valid ? mem[rd_ptr] : '0;

  // Storage write at the tail; reset only needs to clear the bookkeeping, not the data.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + ptr_w'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + ptr_w'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (ptr_w + 1)'(1);
        2'b01:   count <= count - (ptr_w + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/transmitter_queue.sv
// Routes controller words into left/self/right FIFOs, each draining on its own valid/ready link.
// Latency: an accepted word appears on its link the cycle after the write edge when that FIFO is empty.
// Backpressure: writes to a full FIFO or to select 11 are discarded with a registered drop pulse;
// the saturating drop_count is built only when TXQ_DROP_COUNT_EN is defined, otherwise it reads 0.
module transmitter_queue
  import txq_pkg::*;
#(
  parameter int width = 32,
  parameter int depth = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [width-1:0] in_sig,
  input  logic             wr_en,
  input  logic [1:0]       s,
  output logic [2:0]       full,
  output logic             drop,
  output logic [7:0]       drop_count,
  output logic [width-1:0] out_sig_left,
  output logic [width-1:0] out_sig_self,
  output logic [width-1:0] out_sig_right,
  output logic             out_valid_left,
  output logic             out_valid_self,
  output logic             out_valid_right,
  input  logic             out_ready_left,
  input  logic             out_ready_self,
  input  logic             out_ready_right
);

  logic dest_full;
  logic wr_accept;
  logic wr_discard;
  logic push_left_vld;
  logic push_self_vld;
  logic push_right_vld;

  // Full flag of the selected destination; the invalid code has no FIFO behind it.
  always_comb begin
    dest_full = 1'b0;
    case (s)
      DIR_LEFT:  dest_full = full[FULL_IDX_LEFT];
      DIR_SELF:  dest_full = full[FULL_IDX_SELF];
      DIR_RIGHT: dest_full = full[FULL_IDX_RIGHT];
      default:   dest_full = 1'b0;
    endcase
  end

  // Acceptance uses start-of-cycle full, so a same-cycle pop does not rescue a write to a full FIFO.
  assign wr_accept  = wr_en && dir_is_valid(s) && !dest_full;
  assign wr_discard = wr_en && !wr_accept;

  // One-hot push strobes for the three direction FIFOs.
  always_comb begin
    push_left_vld  = 1'b0;
    push_self_vld  = 1'b0;
    push_right_vld = 1'b0;
    if (wr_accept) begin
      case (s)
        DIR_LEFT:  push_left_vld  = 1'b1;
        DIR_SELF:  push_self_vld  = 1'b1;
        DIR_RIGHT: push_right_vld = 1'b1;
        default:   ;
      endcase
    end
  end

  txq_fifo #(.width(width), .depth(depth)) u_fifo_left (
    .clk       (clk),
    .reset     (reset),
    .push      (push_left_vld),
    .push_data (in_sig),
    .pop       (out_ready_left),
    .head      (out_sig_left),
    .valid     (out_valid_left),
    .full      (full[FULL_IDX_LEFT])
  );

  txq_fifo #(.width(width), .depth(depth)) u_fifo_self (
    .clk       (clk),
    .reset     (reset),
    .push      (push_self_vld),
    .push_data (in_sig),
    .pop       (out_ready_self),
    .head      (out_sig_self),
    .valid     (out_valid_self),
    .full      (full[FULL_IDX_SELF])
  );

  txq_fifo #(.width(width), .depth(depth)) u_fifo_right (
    .clk       (clk),
    .reset     (reset),
    .push      (push_right_vld),
    .push_data (in_sig),
    .pop       (out_ready_right),
    .head      (out_sig_right),
    .valid     (out_valid_right),
    .full      (full[FULL_IDX_RIGHT])
  );

  // Drop pulse lasts exactly the cycle after a discarded write.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop <= 1'b0;
    end else begin
      drop <= wr_discard;
    end
  end

`ifdef TXQ_DROP_COUNT_EN
  logic [7:0] drop_cnt_q;

  // Saturating discard counter, stepping on the same edge that raises drop.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_q <= 8'h00;
    end else if (wr_discard && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_q <= drop_cnt_q + 8'h01;
    end
  end

  assign drop_count = drop_cnt_q;
`else
  assign drop_count = 8'h00;
`endif

endmodule

// File: tb/tb_transmitter_queue.sv
// Directed bench for transmitter_queue: routing, overflow, invalid select, wrap, mid-run reset.
// Inputs change 1 time unit after a rising edge; outputs are checked at that same point.
// drop_count expectations follow whether TXQ_DROP_COUNT_EN is defined for the build.
module tb_transmitter_queue;

`ifdef TXQ_DROP_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [31:0] in_sig;
  logic        wr_en;
  logic [1:0]  s;
  logic [2:0]  full;
  logic        drop;
  logic [7:0]  drop_count;
  logic [31:0] out_sig_left, out_sig_self, out_sig_right;
  logic        out_valid_left, out_valid_self, out_valid_right;
  logic        out_ready_left, out_ready_self, out_ready_right;

  int checks = 0;
  int errors = 0;
  int drops_seen = 0;
  logic [31:0] lq [$];
  logic [31:0] lexp;

  transmitter_queue #(.width(32), .depth(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_sig          (in_sig),
    .wr_en           (wr_en),
    .s               (s),
    .full            (full),
    .drop            (drop),
    .drop_count      (drop_count),
    .out_sig_left    (out_sig_left),
    .out_sig_self    (out_sig_self),
    .out_sig_right   (out_sig_right),
    .out_valid_left  (out_valid_left),
    .out_valid_self  (out_valid_self),
    .out_valid_right (out_valid_right),
    .out_ready_left  (out_ready_left),
    .out_ready_self  (out_ready_self),
    .out_ready_right (out_ready_right)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [1:0] dst, input logic [31:0] dat);
    wr_en  = 1'b1;
    s      = dst;
    in_sig = dat;
    tick();
    wr_en  = 1'b0;
  endtask

  function automatic logic [31:0] dc_exp(input int n);
    return CNT_EN ? 32'(n) : 32'h0;
  endfunction

  initial begin
    reset = 1'b1; wr_en = 1'b0; s = 2'b00; in_sig = '0;
    out_ready_left = 1'b0; out_ready_self = 1'b0; out_ready_right = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Reset then idle
    check("rst_full", 32'(full), 32'h0);
    check("rst_drop", 32'(drop), 32'h0);
    check("rst_dcnt", 32'(drop_count), 32'h0);
    check("rst_vld", 32'({out_valid_right, out_valid_self, out_valid_left}), 32'h0);
    check("rst_sig_l", out_sig_left, 32'h0);
    check("rst_sig_s", out_sig_self, 32'h0);
    check("rst_sig_r", out_sig_right, 32'h0);

    // Single routing with all readies high
    out_ready_left = 1'b1; out_ready_self = 1'b1; out_ready_right = 1'b1;
    wr_en = 1'b1; s = 2'b00; in_sig = 32'hA5A5_0001;
    tick();
    check("route_vld_l", 32'(out_valid_left), 32'h1);
    check("route_sig_l", out_sig_left, 32'hA5A5_0001);
    s = 2'b10; in_sig = 32'h0000_0002;
    tick();
    wr_en = 1'b0;
    check("route_vld_r", 32'(out_valid_right), 32'h1);
    check("route_sig_r", out_sig_right, 32'h0000_0002);
    check("route_l_popped", 32'(out_valid_left), 32'h0);
    check("route_vld_s", 32'(out_valid_self), 32'h0);
    tick();
    check("route_r_popped", 32'(out_valid_right), 32'h0);
    check("route_nodrop", 32'(drop), 32'h0);

    // Fill self, overflow with the fifth word
    out_ready_self = 1'b0;
    for (int k = 1; k <= 3; k++) write(2'b01, 32'(k));
    check("fill3_full", 32'(full), 32'h0);
    write(2'b01, 32'd4);
    check("fill4_full", 32'(full), 32'b010);
    check("fill4_nodrop", 32'(drop), 32'h0);
    write(2'b01, 32'd5);
    drops_seen++;
    check("ovf_drop", 32'(drop), 32'h1);
    check("ovf_dcnt", 32'(drop_count), dc_exp(drops_seen));
    tick();
    check("ovf_drop_pulse", 32'(drop), 32'h0);
    check("ovf_head", out_sig_self, 32'd1);
    out_ready_self = 1'b1;
    tick();
    check("drain_full_low", 32'(full), 32'h0);
    check("drain_2", out_sig_self, 32'd2);
    for (int k = 3; k <= 4; k++) begin
      tick();
      check("drain_seq", out_sig_self, 32'(k));
    end
    tick();
    check("drain_empty_vld", 32'(out_valid_self), 32'h0);
    check("drain_empty_sig", out_sig_self, 32'h0);

    // Invalid destination
    write(2'b11, 32'hDEAD_BEEF);
    drops_seen++;
    check("inv_drop", 32'(drop), 32'h1);
    check("inv_vld", 32'({out_valid_right, out_valid_self, out_valid_left}), 32'h0);
    check("inv_dcnt", 32'(drop_count), dc_exp(drops_seen));
    tick();
    check("inv_drop_pulse", 32'(drop), 32'h0);

    // Write to full FIFO while it pops in the same cycle: still discarded
    out_ready_self = 1'b0;
    for (int k = 1; k <= 4; k++) write(2'b01, 32'h10 + 32'(k));
    out_ready_self = 1'b1;
    write(2'b01, 32'h99);
    drops_seen++;
    check("fullpop_drop", 32'(drop), 32'h1);
    check("fullpop_dcnt", 32'(drop_count), dc_exp(drops_seen));
    check("fullpop_head", out_sig_self, 32'h12);
    for (int k = 3; k <= 4; k++) begin
      tick();
      check("fullpop_seq", out_sig_self, 32'h10 + 32'(k));
    end
    tick();
    check("fullpop_empty", 32'(out_valid_self), 32'h0);

    // Concurrent push/pop on right with wrap, independent left backpressure
    out_ready_left = 1'b0;
    for (int k = 0; k < 3; k++) begin
      write(2'b00, 32'h200 + 32'(k));
      lq.push_back(32'h200 + 32'(k));
    end
    out_ready_right = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; s = 2'b10; in_sig = 32'h100 + 32'(i);
      out_ready_left = i[0];
      if (out_ready_left && lq.size() != 0) void'(lq.pop_front());
      tick();
      lexp = (lq.size() != 0) ? lq[0] : 32'h0;
      check("wrap_vld_r", 32'(out_valid_right), 32'h1);
      check("wrap_sig_r", out_sig_right, 32'h100 + 32'(i));
      check("wrap_sig_l", out_sig_left, lexp);
      check("wrap_nodrop", 32'(drop), 32'h0);
    end
    wr_en = 1'b0;
    out_ready_left = 1'b0;
    tick();
    check("wrap_r_empty", 32'(out_valid_right), 32'h0);
    check("wrap_l_empty", 32'(out_valid_left), 32'h0);

    // Reset mid-operation discards buffered words
    for (int k = 0; k < 3; k++) write(2'b00, 32'h700 + 32'(k));
    check("mid_vld_l", 32'(out_valid_left), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_vld", 32'(out_valid_left), 32'h0);
    check("mid_rst_full", 32'(full), 32'h0);
    check("mid_rst_sig", out_sig_left, 32'h0);
    check("mid_rst_dcnt", 32'(drop_count), 32'h0);
    out_ready_left = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("mid_no_stale", 32'(out_valid_left), 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
